mem_seq_ctrl: RTL and testbench

Memory access sequencer for the multi-cycle CPU: arbitrates the single shared memory port between instruction fetch and load/store data access, applies a fixed memory latency, and drives the load strobes of the instruction register and the data register (DRr) plus the DRr output gate. It sits between the main control FSM and the memory/DRr/IR datapath. Request handling, address latching and strobe timing all live here, so the control FSM only raises a request and waits for `done`.

---
 rtl/mem_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_seq_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_seq_ctrl.sv
// rtl/mem_seq_ctrl.sv - shared memory port sequencer: arbitration, fixed latency, IR/DRr strobes
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned data requests flagged with ls_err)
module mem_seq_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              ir_in,
    output logic              drr_in,
    output logic              drr_out,
    output logic              if_done,
    output logic              ls_done,
    output logic              ls_err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              cur_data;
    logic              cur_store;
    logic              cur_err;
    logic              ls_misaligned;
    logic [ADDR_W-1:0] ls_addr_eff;

`ifdef MEM_ALIGN_CHECK_EN
    assign ls_misaligned = (ls_addr[1:0] != 2'b00);
    assign ls_addr_eff   = ls_addr;
`else
    // Without the check the word offset is simply dropped.
    assign ls_misaligned = 1'b0;
    assign ls_addr_eff   = ls_addr & ~ADDR_W'(3);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_data  <= 1'b0;
            cur_store <= 1'b0;
            cur_err   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ir_in     <= 1'b0;
            drr_in    <= 1'b0;
            drr_out   <= 1'b0;
            if_done   <= 1'b0;
            ls_done   <= 1'b0;
            ls_err    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ir_in   <= 1'b0;
            drr_in  <= 1'b0;
            if_done <= 1'b0;
            ls_done <= 1'b0;
            ls_err  <= 1'b0;
            case (state)
                IDLE: begin
                    // Data access wins: it belongs to the older instruction.
                    if (ls_req) begin
                        drr_out   <= 1'b0;
                        busy      <= 1'b1;
                        cur_data  <= 1'b1;
                        cur_store <= ls_we;
                        cur_err   <= ls_misaligned;
                        mem_addr  <= ls_addr_eff;
                        mem_wdata <= ls_wdata;
                        cnt       <= CNT_INIT;
                        if (ls_misaligned) begin
                            state   <= CAPTURE;
                            ls_err  <= 1'b1;
                            ls_done <= 1'b1;
                        end else begin
                            state  <= ACCESS;
                            mem_en <= 1'b1;
                            mem_we <= ls_we;
                        end
                    end else if (if_req) begin
                        drr_out   <= 1'b0;
                        busy      <= 1'b1;
                        cur_data  <= 1'b0;
                        cur_store <= 1'b0;
                        cur_err   <= 1'b0;
                        mem_addr  <= if_addr;
                        cnt       <= CNT_INIT;
                        state     <= ACCESS;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state  <= CAPTURE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (cur_data) begin
                            ls_done <= 1'b1;
                            drr_in  <= ~cur_store;
                        end else begin
                            if_done <= 1'b1;
                            ir_in   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    // DRr is gated onto the bus only after a completed load.
                    if (cur_data && !cur_store && !cur_err)
                        drr_out <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// tb/tb_mem_seq_ctrl.sv - self-checking bench for mem_seq_ctrl against a transaction-level timeline model
module tb_mem_seq_ctrl;

    localparam int W = 2;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic        mem_en, mem_we, ir_in, drr_in, drr_out, if_done, ls_done, ls_err, busy;
    logic [31:0] mem_addr, mem_wdata;

    int checks = 0;
    int errors = 0;
    bit last_load = 1'b0;

    // {mem_en, mem_we, ir_in, drr_in, drr_out, if_done, ls_done, ls_err, busy}
    logic [8:0] got;
    assign got = {mem_en, mem_we, ir_in, drr_in, drr_out, if_done, ls_done, ls_err, busy};

    mem_seq_ctrl #(.WAIT_CYCLES(W), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .ir_in(ir_in), .drr_in(drr_in), .drr_out(drr_out),
        .if_done(if_done), .ls_done(ls_done), .ls_err(ls_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Called at a negedge while the DUT is idle; the request is accepted on the next posedge.
    task automatic do_txn(input bit data, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input bit both, input string tag);
        logic [8:0]  exp;
        logic [31:0] ea;
        bit          err;
        err = ALIGN_CHK && data && (addr[1:0] != 2'b00);
        ea  = (data && !ALIGN_CHK) ? (addr & 32'hFFFF_FFFC) : addr;
        if (data) begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wd;
            if (both) if_req = 1'b1;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        if (!err) begin
            for (int k = 1; k <= W; k++) begin
                @(negedge clk);
                exp = {1'b1, data && we, 7'b000_0001};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL %s access%0d flags: got %b expected %b", tag, k, got, exp);
                end
                checks++;
                if (mem_addr !== ea) begin
                    errors++;
                    $display("FAIL %s access%0d mem_addr: got %h expected %h", tag, k, mem_addr, ea);
                end
                if (data && we) begin
                    checks++;
                    if (mem_wdata !== wd) begin
                        errors++;
                        $display("FAIL %s access%0d mem_wdata: got %h expected %h", tag, k, mem_wdata, wd);
                    end
                end
                // Inputs moving mid-transfer must not leak through.
                ls_addr = $urandom; ls_wdata = $urandom; ls_we = 1'($urandom);
                if (data) if_addr = $urandom;
            end
        end
        @(negedge clk);
        exp = {2'b00, !data, data && !we && !err, 1'b0, !data, data, err, 1'b1};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s capture flags: got %b expected %b", tag, got, exp);
        end
        if (data) ls_req = 1'b0; else if_req = 1'b0;
        @(negedge clk);
        last_load = data && !we && !err;
        exp = {4'b0000, last_load, 4'b0000};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s idle flags: got %b expected %b", tag, got, exp);
        end
        checks++;
        if (mem_addr !== ea) begin
            errors++;
            $display("FAIL %s idle mem_addr hold: got %h expected %h", tag, mem_addr, ea);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({got, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset state: got %b %h %h expected all zero", got, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (got !== 9'b0) begin
            errors++;
            $display("FAIL post-reset idle: got %b expected 0", got);
        end
    endtask

    task automatic test_fetch();
        do_txn(1'b0, 1'b0, 32'h0000_3000, 32'h0, 1'b0, "fetch");
    endtask

    task automatic test_load_store();
        do_txn(1'b1, 1'b0, 32'h0000_1004, 32'h0, 1'b0, "load");
        @(negedge clk);
        checks++;
        if (drr_out !== 1'b1) begin
            errors++;
            $display("FAIL load drr_out hold: got %b expected 1", drr_out);
        end
        do_txn(1'b1, 1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 1'b0, "store");
    endtask

    task automatic test_priority();
        do_txn(1'b1, 1'b0, 32'h0000_2010, 32'h0, 1'b1, "prio_data");
        do_txn(1'b0, 1'b0, 32'h0000_4000, 32'h0, 1'b0, "prio_fetch");
    endtask

    task automatic test_reset_mid();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_2000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({got, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL mid-access reset: got %b %h %h expected all zero", got, mem_addr, mem_wdata);
        end
        #1 rst = 1'b0;
        do_txn(1'b1, 1'b0, 32'h0000_2000, 32'h0, 1'b0, "reaccept");
    endtask

    task automatic test_misaligned();
        do_txn(1'b1, 1'b0, 32'h0000_1002, 32'h0, 1'b0, "misalign_load");
        do_txn(1'b1, 1'b1, 32'h0000_1003, 32'h1234_5678, 1'b0, "misalign_store");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            do_txn(1'b0, 1'b0, 32'h0000_0100 + 32'(i * 4), 32'h0, 1'b0, "b2b_fetch");
        do_txn(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b0, "b2b_load");
        do_txn(1'b1, 1'b1, 32'h0000_0204, 32'hA5A5_5A5A, 1'b0, "b2b_store");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            bit          d, w, b;
            logic [31:0] a, wd;
            int          gap;
            d = 1'($urandom); w = 1'($urandom); b = 1'($urandom);
            a = $urandom; wd = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_txn(d, w, a, wd, d && b, "random");
            if (d && b)
                do_txn(1'b0, 1'b0, $urandom & 32'hFFFF_FFFC, 32'h0, 1'b0, "random_queued");
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checks++;
                if (got !== {4'b0000, last_load, 4'b0000}) begin
                    errors++;
                    $display("FAIL random gap flags: got %b expected %b", got, {4'b0000, last_load, 4'b0000});
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_load_store();
        test_priority();
        test_reset_mid();
        test_misaligned();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
